// File: rtl/fft_sram_responder_if.sv
// Bundle of the FFT engine and host-side signals seen by the working-store responder.
// The master modport drives requests; the slave modport is the responder.
interface fft_sram_responder_if #(
  parameter int AW = 8,
  parameter int DW = 128
);
  logic          i_working;
  logic          i_fft_done;
  logic [AW-1:0] i_raddress1;
  logic [AW-1:0] i_raddress2;
  logic [DW-1:0] o_rdata1;
  logic [DW-1:0] o_rdata2;
  logic [AW-1:0] i_waddress1;
  logic [AW-1:0] i_waddress2;
  logic [DW-1:0] i_wdata1;
  logic [DW-1:0] i_wdata2;
  logic          i_global_write_enable;
  logic          i_host_valid;
  logic          o_host_ready;
  logic          i_host_we;
  logic [AW-1:0] i_host_addr;
  logic [DW-1:0] i_host_wdata;
  logic          o_host_rvalid;
  logic [DW-1:0] o_host_rdata;
  logic          o_wcollision;
  logic          o_late_write;
  logic [15:0]   o_write_count;

  modport master (
    output i_working, i_fft_done, i_raddress1, i_raddress2,
           i_waddress1, i_waddress2, i_wdata1, i_wdata2, i_global_write_enable,
           i_host_valid, i_host_we, i_host_addr, i_host_wdata,
    input  o_rdata1, o_rdata2, o_host_ready, o_host_rvalid, o_host_rdata,
           o_wcollision, o_late_write, o_write_count
  );

  modport slave (
    input  i_working, i_fft_done, i_raddress1, i_raddress2,
           i_waddress1, i_waddress2, i_wdata1, i_wdata2, i_global_write_enable,
           i_host_valid, i_host_we, i_host_addr, i_host_wdata,
    output o_rdata1, o_rdata2, o_host_ready, o_host_rvalid, o_host_rdata,
           o_wcollision, o_late_write, o_write_count
  );
endinterface

// File: rtl/fft_sram_responder.sv
// FFT working-store SRAM responder: dual read, dual write, host load/unload, ownership FSM.
// Define FFT_SRAM_BYPASS_EN for a write-first read path; default is read-first.
module fft_sram_responder #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_sram_responder_if.slave   bus
);

  typedef enum logic [1:0] {ST_HOST, ST_RUN, ST_DONE} state_t;

  logic [DW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic          wcoll_q, wcoll_d;
  logic          late_q, late_d;
  logic [15:0]   wcount_q, wcount_d;

  logic [DW-1:0] rdata1_p1, rdata2_p1, host_rdata_p1;
  logic          vld_p1;

  logic          host_ready;
  logic          host_wr;
  logic          host_rd;
  logic          fft_wr;
  logic          late_hit;
  logic          coll_hit;
  logic [DW-1:0] rd1_p0, rd2_p0, hrd_p0;

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    sat_inc = (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

`ifdef FFT_SRAM_BYPASS_EN
  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] a, input logic [DW-1:0] old);
    fwd = old;
    if (host_wr && bus.i_host_addr == a) fwd = bus.i_host_wdata;
    if (fft_wr && bus.i_waddress1 == a)  fwd = bus.i_wdata1;
    if (fft_wr && bus.i_waddress2 == a)  fwd = bus.i_wdata2;
  endfunction
`endif

  always_comb begin
    host_ready = (state_q == ST_HOST) && !bus.i_working && !rst;
    host_wr    = bus.i_host_valid && host_ready && bus.i_host_we;
    host_rd    = bus.i_host_valid && host_ready && !bus.i_host_we;
    fft_wr     = (state_q == ST_RUN) && bus.i_global_write_enable;
    late_hit   = (state_q == ST_DONE) && bus.i_global_write_enable;
    coll_hit   = fft_wr && (bus.i_waddress1 == bus.i_waddress2);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOST: if (bus.i_working) state_d = ST_RUN;
      ST_RUN: begin
        if (!bus.i_working)      state_d = ST_HOST;
        else if (bus.i_fft_done) state_d = ST_DONE;
      end
      ST_DONE: if (!bus.i_working) state_d = ST_HOST;
      default: state_d = ST_HOST;
    endcase
    wcoll_d  = wcoll_q | coll_hit;
    late_d   = late_q | late_hit;
    wcount_d = fft_wr ? sat_inc(wcount_q) : wcount_q;
  end

  // Stage p0: array lookup, with same-edge write forwarding when bypass is built in
  always_comb begin
    rd1_p0 = mem[bus.i_raddress1];
    rd2_p0 = mem[bus.i_raddress2];
    hrd_p0 = mem[bus.i_host_addr];
`ifdef FFT_SRAM_BYPASS_EN
    rd1_p0 = fwd(bus.i_raddress1, rd1_p0);
    rd2_p0 = fwd(bus.i_raddress2, rd2_p0);
    hrd_p0 = fwd(bus.i_host_addr, hrd_p0);
`endif
  end

  // Port 2 is written last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (fft_wr) begin
      mem[bus.i_waddress1] <= bus.i_wdata1;
      mem[bus.i_waddress2] <= bus.i_wdata2;
    end
    if (host_wr) mem[bus.i_host_addr] <= bus.i_host_wdata;
  end

  // Stage p1: registered read data and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HOST;
      wcoll_q       <= 1'b0;
      late_q        <= 1'b0;
      wcount_q      <= 16'd0;
      vld_p1        <= 1'b0;
      rdata1_p1     <= '0;
      rdata2_p1     <= '0;
      host_rdata_p1 <= '0;
    end else begin
      state_q   <= state_d;
      wcoll_q   <= wcoll_d;
      late_q    <= late_d;
      wcount_q  <= wcount_d;
      vld_p1    <= host_rd;
      rdata1_p1 <= rd1_p0;
      rdata2_p1 <= rd2_p0;
      if (host_rd) host_rdata_p1 <= hrd_p0;
    end
  end

  assign bus.o_rdata1      = rdata1_p1;
  assign bus.o_rdata2      = rdata2_p1;
  assign bus.o_host_ready  = host_ready;
  assign bus.o_host_rvalid = vld_p1;
  assign bus.o_host_rdata  = host_rdata_p1;
  assign bus.o_wcollision  = wcoll_q;
  assign bus.o_late_write  = late_q;
  assign bus.o_write_count = wcount_q;

endmodule

// File: doc/fft_sram_responder.md
# fft_sram_responder

Responder end of the FFT engine's memory interface: a 256x128 working-store SRAM model with two synchronous read ports, two write ports under a single global write enable, and a host load/unload port. It sits beside `fft_top` and returns read data one cycle after each address. Ownership passes from the host to the FFT engine on `i_working` and back after `i_fft_done`. It also flags write collisions and writes that arrive after the FFT has completed.

## Interface
- `DEPTH`, 256, number of words
- `AW`, 8, address width (log2 DEPTH)
- `DW`, 128, word width (four 32-bit complex samples)
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `i_working` in 1: FFT owns memory while high
- `i_fft_done` in 1: FFT completion strobe or level from the engine
- `i_raddress1`, `i_raddress2` in AW: FFT read addresses
- `o_rdata1`, `o_rdata2` out DW: registered read data
- `i_waddress1`, `i_waddress2` in AW: FFT write addresses
- `i_wdata1`, `i_wdata2` in DW: FFT write data
- `i_global_write_enable` in 1: commits both FFT write ports in the same cycle
- `i_host_valid` in 1: host request
- `o_host_ready` out 1: host request accepted this cycle
- `i_host_we` in 1: 1 = write, 0 = read
- `i_host_addr` in AW: host address
- `i_host_wdata` in DW: host write data
- `o_host_rvalid` out 1: host read data valid
- `o_host_rdata` out DW: host read data
- `o_wcollision` out 1: sticky; both FFT write ports targeted the same address
- `o_late_write` out 1: sticky; FFT write seen in DONE state
- `o_write_count` out 16: number of committed FFT write cycles (saturating)

## Operation
- FSM states: HOST (reset state), RUN, DONE.
  - HOST -> RUN when `i_working`=1.
  - RUN -> DONE when `i_fft_done`=1.
  - DONE -> HOST when `i_working`=0.
  - RUN -> HOST if `i_working` drops before done (abort).
- HOST state:
  - `o_host_ready`=1 and `i_working`=0.
  - An accepted write stores `i_host_wdata` at `i_host_addr`.
  - An accepted read returns `o_host_rdata` with `o_host_rvalid`=1 exactly one cycle later.
  - FFT write ports are ignored.
- RUN state:
  - `o_host_ready`=0.
  - If `i_global_write_enable`=1, port 1 and port 2 both write.
  - If `i_waddress1`==`i_waddress2`, port 2 data wins and `o_wcollision` is set.
  - Each enabled cycle increments `o_write_count` by 1, saturating at 16'hFFFF.
- DONE state:
  - FFT writes are discarded, memory is unchanged, and `o_late_write` is set.
  - The host port stays blocked until the return to HOST.
- FFT reads are serviced in every state, so the engine may prefetch before RUN.
- Read-during-write to the same address is read-first by default: the old data is returned.
- Reset clears the FSM to HOST and zeroes every output. Memory contents are not reset.
  - Reset mid-RUN abandons the FFT immediately.
  - Sticky flags and the counter clear only on reset.

## Timing
- FFT read latency is 1 cycle. `o_rdata*` updates on the edge after the address is presented, matching a block-RAM model.
- Writes commit on the rising edge where the enable is sampled high.
- A host read has 1-cycle latency. A host request seen on the same edge as the HOST->RUN transition is not accepted: `o_host_ready` is evaluated combinationally from the current state and `i_working`.
- `o_host_rvalid` is a single-cycle pulse.
- The state transition and the flag update on a given edge both use inputs sampled at that edge.

## Configuration
- `FFT_SRAM_BYPASS_EN`:
  - Defined: the read path is write-first. If a read address equals a write address committed on the same edge, `o_rdata*` returns the new data. Port 2 takes priority on collision. This applies to FFT and host reads.
  - Undefined: the read path is read-first and returns the pre-write contents.

## Test plan
- Host load and readback: host writes 128'hA5..01 to address 3, then reads address 3. Required: `o_host_rvalid`=1 one cycle after acceptance, with matching data.
- FFT 1-cycle latency: in RUN, `i_raddress1`=3 and `i_raddress2`=4 at cycle n. Required: `o_rdata1`/`o_rdata2` equal sram[3]/sram[4] at cycle n+1.
- Dual write with collision: `i_global_write_enable`=1, both addresses=10, data X and Y. Required: sram[10]=Y, `o_wcollision`=1, `o_write_count`=1.
- Read-during-write to address 5 (old value P, new value Q):
  - Macro undefined: `o_rdata1`=P.
  - Macro defined: `o_rdata1`=Q.
- Late write: raise `i_fft_done`, then assert a write to address 7. Required: sram[7] is unchanged and `o_late_write`=1. After `i_working`=0, `o_host_ready`=1.
- Reset mid-RUN: assert `rst` during RUN. Required: next cycle the FSM is in HOST, all outputs are 0, and the host read of sram[10] still returns Y.
